// File: rtl/bnn_weight_streamer.sv
// bnn_weight_streamer: turns valid/ready weight bytes into load_en-qualified lo/hi nibble pairs
module bnn_weight_streamer #(
    parameter int NUM_NEURONS = 12,
    parameter int IDX_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ena,
    input  logic             i_start,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte_data,
    output logic             o_byte_ready,
    output logic             o_load_en,
    output logic [3:0]       o_weight_nib,
    output logic [IDX_W-1:0] o_neuron_idx,
    output logic             o_busy,
    output logic             o_done
);
    localparam logic [2:0] IDLE = 3'd0, WAIT_BYTE = 3'd1, NIB_LO = 3'd2, NIB_HI = 3'd3, DONE = 3'd4;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);
    logic [2:0]       r_state, w_state_nx;
    logic [IDX_W-1:0] r_count, w_count_nx;
    logic [7:0]       r_hold, w_hold_nx;
    logic             r_load_en, w_last, w_hs;
    always_comb begin
        w_last = r_count == LAST;
        o_byte_ready = i_ena && (r_state == WAIT_BYTE || (r_state == NIB_HI && !w_last));
        w_hs = o_byte_ready && i_byte_valid;
        w_hold_nx = w_hs ? i_byte_data : r_hold;
        w_count_nx = (r_state == IDLE && i_start) ? '0 : (r_state == NIB_HI) ? r_count + IDX_W'(1) : r_count;
        w_state_nx = IDLE;
        case (r_state)
            IDLE:      w_state_nx = i_start ? WAIT_BYTE : IDLE;
            WAIT_BYTE: w_state_nx = w_hs ? NIB_LO : WAIT_BYTE;
            NIB_LO:    w_state_nx = NIB_HI;
            NIB_HI:    w_state_nx = w_last ? DONE : w_hs ? NIB_LO : WAIT_BYTE;
            default:   w_state_nx = IDLE;
        endcase
    end
    // outputs are registered from the next-state decode so they line up with the state they describe
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_hold       <= '0;
            r_load_en    <= 1'b0;
            o_weight_nib <= '0;
            o_neuron_idx <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else if (i_ena) begin
            r_state      <= w_state_nx;
            r_count      <= w_count_nx;
            r_hold       <= w_hold_nx;
            r_load_en    <= w_state_nx == NIB_LO || w_state_nx == NIB_HI;
            o_weight_nib <= w_state_nx == NIB_HI ? w_hold_nx[7:4] : w_hold_nx[3:0];
            o_neuron_idx <= w_count_nx;
            o_busy       <= w_state_nx != IDLE;
            o_done       <= w_state_nx == DONE;
        end
    end
    assign o_load_en = r_load_en && i_ena;
endmodule

// File: tb/tb_bnn_weight_streamer.sv
// tb_bnn_weight_streamer: randomized sessions checked against a byte-list nibble-stream model
module tb_bnn_weight_streamer;
    localparam int N = 12;
    logic       clk = 0, reset = 1, ena = 1, start = 0, start1 = 0, byte_valid = 0;
    logic [7:0] byte_data = 0;
    logic       ready, load_en, busy, done, ready1, load_en1, busy1, done1;
    logic [3:0] nib, idx, nib1, idx1;
    logic [7:0] bytes [N];
    int         vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    bnn_weight_streamer dut (
        .i_clk(clk), .i_reset(reset), .i_ena(ena), .i_start(start),
        .i_byte_valid(byte_valid), .i_byte_data(byte_data), .o_byte_ready(ready),
        .o_load_en(load_en), .o_weight_nib(nib), .o_neuron_idx(idx),
        .o_busy(busy), .o_done(done)
    );

    bnn_weight_streamer #(.NUM_NEURONS(1)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_ena(ena), .i_start(start1),
        .i_byte_valid(byte_valid), .i_byte_data(byte_data), .o_byte_ready(ready1),
        .o_load_en(load_en1), .o_weight_nib(nib1), .o_neuron_idx(idx1),
        .o_busy(busy1), .o_done(done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one session on dut; the expected stream is simply bytes[] split into lo,hi nibbles.
    task automatic session(input int gap_pct, input int ena_pct, input bit poke_start, output int done_cyc);
        logic [3:0] obs_nib [$];
        int         obs_idx [$];
        int         sent = 0, orphans = 0, gated_bad = 0;
        bit         pend = 0;
        done_cyc = -1;
        for (int c = 0; c < 3000 && done_cyc < 0; c++) begin
            @(negedge clk);
            start = (c == 0) || (poke_start && $urandom_range(9) == 0);
            ena = (c == 0) || ($urandom_range(99) >= ena_pct);
            byte_valid = $urandom_range(99) >= gap_pct;
            byte_data = sent < N ? bytes[sent] : 8'h99;
            #1;
            if (!ena) begin
                if (load_en || ready) gated_bad++;
            end else begin
                if (load_en) begin
                    obs_nib.push_back(nib);
                    obs_idx.push_back(int'(idx));
                    pend = !pend;
                end else if (pend) orphans++;
                if (byte_valid && ready) sent++;
                if (done) done_cyc = c;
            end
        end
        check("done_seen", done_cyc >= 0, 1);
        check("handshakes", sent, N);
        check("nibble_count", obs_nib.size(), 2 * N);
        for (int i = 0; i < 2 * N && i < obs_nib.size(); i++) begin
            check($sformatf("nib[%0d]", i), obs_nib[i], (i % 2 != 0) ? bytes[i / 2][7:4] : bytes[i / 2][3:0]);
            check($sformatf("idx[%0d]", i), obs_idx[i], i / 2);
        end
        check("orphans", orphans, 0);
        check("gated", gated_bad, 0);
        @(negedge clk);
        start = 0; byte_valid = 0; ena = 1;
        #1;
        check("post_done", done, 0);
        check("post_busy", busy, 0);
    endtask

    initial begin
        int dc;
        bit p, hit;
        byte_valid = 1; byte_data = 8'hFF;
        repeat (3) @(negedge clk);
        #1;
        check("rst_load_en", load_en, 0);
        check("rst_nib", nib, 0);
        check("rst_idx", idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", ready, 0);
        check("rst_ready1", ready1, 0);
        @(negedge clk); reset = 0; byte_valid = 0; start1 = 1;
        @(negedge clk); start1 = 0; byte_valid = 1; byte_data = 8'hA5; #1;
        check("s_ready", ready1, 1);
        @(negedge clk); #1;
        check("s_lo_en", load_en1, 1);
        check("s_lo_nib", nib1, 4'h5);
        check("s_lo_idx", idx1, 0);
        check("s_lo_ready", ready1, 0);
        @(negedge clk); #1;
        check("s_hi_en", load_en1, 1);
        check("s_hi_nib", nib1, 4'hA);
        check("s_hi_idx", idx1, 0);
        check("s_hi_ready", ready1, 0);
        @(negedge clk); byte_valid = 0; #1;
        check("s_done", done1, 1);
        check("s_done_en", load_en1, 0);
        check("s_done_busy", busy1, 1);
        @(negedge clk); #1;
        check("s_after_done", done1, 0);
        check("s_after_busy", busy1, 0);
        @(negedge clk); start1 = 1;
        @(negedge clk); start1 = 0; byte_valid = 1; byte_data = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); ena = 0; byte_valid = 0; #1;
            check("drop_en", load_en1, 0);
            check("drop_idx", idx1, 0);
        end
        @(negedge clk); ena = 1; #1;
        check("resume_lo_en", load_en1, 1);
        check("resume_lo_nib", nib1, 4'hC);
        @(negedge clk); #1;
        check("resume_hi_en", load_en1, 1);
        check("resume_hi_nib", nib1, 4'h3);
        check("resume_idx", idx1, 0);
        @(negedge clk); #1;
        check("resume_done", done1, 1);
        @(negedge clk);
        bytes = '{8'hA0, 8'h41, 8'h7A, 8'h18, 8'hED, 8'hB7, 8'h67, 8'h3A, 8'hF9, 8'h62, 8'hF7, 8'h0F};
        session(0, 0, 0, dc);
        check("done_latency", dc, 2 * N + 2);
        session(50, 0, 1, dc);
        for (int r = 0; r < 2; r++) begin
            foreach (bytes[i]) bytes[i] = 8'($urandom);
            session(30, 30, 1, dc);
        end
        @(negedge clk); start = 1; byte_valid = 1;
        p = 0; hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk); start = 0; byte_data = 8'($urandom); #1;
            if (load_en) p = !p;
            hit = load_en && !p && idx == 4'd5;
        end
        check("reach_nib_hi_5", hit, 1);
        reset = 1;
        @(negedge clk); reset = 0; #1;
        check("midrst_en", load_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", ready, 0);
        check("midrst_idx", idx, 0);
        foreach (bytes[i]) bytes[i] = 8'($urandom);
        session(0, 0, 1, dc);
        check("restart_latency", dc, 2 * N + 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bnn_weight_streamer.md
# bnn_weight_streamer

Transmit side of the BNN nibble-serial weight-load interface. Accepts one 8-bit weight byte per neuron over a valid/ready byte port and emits each byte as two consecutive `load_en`-qualified nibbles, low nibble first. The outputs drive the inference core's `uio_in[7:4]` (nibble) and `uio_in[3]` (load enable). One programming session writes `NUM_NEURONS` bytes, for neurons 0..NUM_NEURONS-1 in order, then reports completion.

## Interface
- `NUM_NEURONS`, default 12: bytes per session; the receiver's neuron count.
- `IDX_W`, default 4: width of `neuron_idx`; must satisfy 2^IDX_W >= NUM_NEURONS.

- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ena`  in  1  global enable; low freezes all state.
- `start`  in  1  pulse that begins a session; honoured only in IDLE with `ena`=1.
- `byte_valid`  in  1  upstream byte available.
- `byte_data`  in  8  weight byte; bit 7 pairs with input bit 7 of the target neuron.
- `byte_ready`  out  1  streamer accepts a byte this cycle.
- `load_en`  out  1  nibble valid to receiver (maps to `uio_in[3]`).
- `weight_nib`  out  4  nibble to receiver (maps to `uio_in[7:4]`).
- `neuron_idx`  out  IDX_W  index of the neuron whose byte is on `weight_nib`.
- `busy`  out  1  session in progress (any state other than IDLE).
- `done`  out  1  one-cycle pulse after the last high nibble.

## Operation
- FSM states: IDLE, WAIT_BYTE, NIB_LO, NIB_HI, DONE.
- IDLE + `start` -> WAIT_BYTE. Byte count is cleared to 0 on this transition.
- WAIT_BYTE: `byte_ready`=1. When `byte_valid`=1, latch `byte_data` into the holding register and go to NIB_LO.
- NIB_LO: `load_en`=1, `weight_nib`=hold[3:0]. Always goes to NIB_HI.
- NIB_HI: `load_en`=1, `weight_nib`=hold[7:4]. At the end of this cycle the byte count increments. Next state:
  - count+1 == NUM_NEURONS -> DONE.
  - otherwise, `byte_ready`=1 in this cycle; if `byte_valid`=1, latch the new byte and go to NIB_LO (back-to-back streaming); else go to WAIT_BYTE.
- DONE: `done`=1 for one cycle, then -> IDLE.
- `byte_ready` is 0 in IDLE, NIB_LO and DONE, and 0 in NIB_HI for the final byte. Extra upstream bytes are never consumed.
- `neuron_idx` equals the byte count. It is valid whenever `load_en`=1 and is the same for both nibbles of a pair.
- Protocol invariant: nibbles always come in adjacent lo/hi pairs. `load_en` is never asserted for an unpaired nibble. Gaps (`load_en`=0) occur only between pairs.
- `ena`=0:
  - FSM, count, holding register and all registered outputs hold their values.
  - `load_en` and `byte_ready` are forced to 0 combinationally.
  - A pair interrupted by `ena` resumes on the next enabled cycle. This is safe because the receiver also ignores `load_en` while `ena`=0.
- `start` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE; count 0; holding register 0x00.
  - `load_en`=0, `weight_nib`=0, `neuron_idx`=0, `busy`=0, `done`=0, `byte_ready`=0.
- `reset` mid-session returns to IDLE on the next edge and abandons any half-sent pair. The receiver must be reset in the same cycle.
- `weight_nib`, `load_en`, `neuron_idx`, `busy` and `done` are registered, except for the `ena` gating described above.
- Latency:
  - `start` edge -> WAIT_BYTE, so `byte_ready`=1 in the next cycle.
  - Byte accepted at edge k -> low nibble in cycle k+1, high nibble in cycle k+2.
- Throughput: one byte per 2 cycles with `byte_valid` held high. A full session with continuous upstream and `ena`=1 takes 1 + 2·NUM_NEURONS + 1 cycles from `start` to the `done` cycle (26 for the default).
- A handshake occurs only when `byte_valid` and `byte_ready` are both 1 at a rising edge. `byte_data` is sampled only then.
- `busy` falls on the edge leaving DONE.

## Test plan
- **Reset state.** Assert `reset` 2 cycles -> all outputs 0; state IDLE; `byte_ready`=0 with `byte_valid`=1.
- **Single-byte nibble order.** NUM_NEURONS=1; `start`, then byte 0xA5 -> `load_en`=1 with nib 0x5, then nib 0xA, `neuron_idx`=0 on both, `done` in the following cycle, `busy` low after.
- **Full default session, continuous upstream.** Bytes 0xA0, 0x41, 0x7A, 0x18, 0xED, 0xB7, 0x67, 0x3A, 0xF9, 0x62, 0xF7, 0x0F ->
  - `load_en` high for 24 consecutive cycles with nibbles 0,A,1,4,A,7,…,F,0;
  - `neuron_idx` steps 0..11, each value held for 2 cycles;
  - `done` 26 cycles after `start`;
  - the 13th byte offered is not accepted.
- **Upstream stalls.** `byte_valid` toggled with random gaps -> `load_en` is low only between pairs and never for a lone nibble; the sequence is identical to the continuous case.
- **`ena` dropped in NIB_LO.** Drop `ena` for 3 cycles during NIB_LO of byte 0x3C -> `load_en`=0 for those 3 cycles, then nib 0xC and 0x3 on the next two enabled cycles; `neuron_idx` unchanged.
- **Reset mid-session and ignored start.** Assert `reset` during NIB_HI of neuron 5 -> IDLE next cycle with `load_en`=0; a new `start` restarts at `neuron_idx`=0. `start` pulsed while `busy`=1 -> no effect on count or state.
